// File: rtl/tes_vehicle_plant_pkg.sv
// Shared widths, door actuator states and the gap clamp used by the vehicle plant.
package tes_vehicle_plant_pkg;

    localparam int SPEED_W  = 8;
    localparam int DIST_W   = 7;
    localparam int DIST_MAX = 127;

    typedef enum logic [1:0] {
        DOOR_LOCKED    = 2'd0,
        DOOR_UNLOCKING = 2'd1,
        DOOR_OPEN      = 2'd2,
        DOOR_LOCKING   = 2'd3
    } door_state_t;

    // Saturate a signed gap candidate into the unsigned distance range.
    function automatic logic [DIST_W-1:0] clamp_dist(input logic signed [9:0] value);
        if (value < 10'sd0)
            return '0;
        else if (value > 10'sd127)
            return DIST_W'(DIST_MAX);
        else
            return value[DIST_W-1:0];
    endfunction

endpackage

// File: rtl/tes_tick_gen.sv
// Free-running dynamics tick generator: one-clock pulse every TICK_DIV clocks.
module tes_tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int              CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (count == LAST)
            count <= '0;
        else
            count <= count + 1'b1;
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/tes_vehicle_plant.sv
// Vehicle plant closing the loop around tes_fsm: speed ramp, gap tracking, timed door lock.
module tes_vehicle_plant
    import tes_vehicle_plant_pkg::*;
#(
    parameter int TICK_DIV   = 4,
    parameter int ACCEL_STEP = 2,
    parameter int DECEL_STEP = 3,
    parameter int MAX_SPEED  = 200,
    parameter int DIST_SHIFT = 4,
    parameter int DOOR_DLY   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               accelerate_car,
    input  logic               unlock_doors,
    input  logic [SPEED_W-1:0] lead_speed,
    input  logic               load_en,
    input  logic [SPEED_W-1:0] load_speed,
    input  logic [DIST_W-1:0]  load_distance,
    output logic [SPEED_W-1:0] car_speed,
    output logic [DIST_W-1:0]  leading_distance,
    output logic               doors_open,
    output logic               door_busy,
    output logic               tick,
    output logic               collision
);

    localparam int            DW        = $clog2(DOOR_DLY + 1);
    localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_DLY - 1);
    localparam logic [8:0]    ACCEL9    = 9'(ACCEL_STEP);
    localparam logic [8:0]    DECEL9    = 9'(DECEL_STEP);
    localparam logic [8:0]    MAX9      = 9'(MAX_SPEED);

    door_state_t          door_state, door_next;
    logic [DW-1:0]        door_cnt, door_cnt_next;
    logic [8:0]           speed_up, speed_wide;
    logic [SPEED_W-1:0]   speed_next;
    logic signed [9:0]    speed_diff, dist_delta, dist_sum;
    logic [DIST_W-1:0]    dist_next;
    logic                 accel_ok;

    tes_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Speed is widened to 9 bits so neither the ramp nor the decay can wrap.
    always_comb begin
        accel_ok   = accelerate_car && (door_state == DOOR_LOCKED) && !collision;
        speed_wide = {1'b0, car_speed};
        speed_up   = speed_wide + ACCEL9;
        speed_next = '0;
        if (accel_ok)
            speed_next = (speed_up > MAX9) ? MAX9[SPEED_W-1:0] : speed_up[SPEED_W-1:0];
        else if (speed_wide >= DECEL9)
            speed_next = 8'(speed_wide - DECEL9);
    end

    // Gap change uses the speed before this tick's update; arithmetic shift floors negatives.
    always_comb begin
        speed_diff = $signed({2'b00, lead_speed}) - $signed({2'b00, car_speed});
        dist_delta = speed_diff >>> DIST_SHIFT;
        dist_sum   = $signed({3'b000, leading_distance}) + dist_delta;
        dist_next  = clamp_dist(dist_sum);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            car_speed        <= '0;
            leading_distance <= DIST_W'(DIST_MAX);
            collision        <= 1'b0;
        end else if (load_en) begin
            car_speed        <= load_speed;
            leading_distance <= load_distance;
            collision        <= 1'b0;
        end else if (tick) begin
            car_speed        <= speed_next;
            leading_distance <= dist_next;
            if (dist_next == '0)
                collision <= 1'b1;
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        door_next     = door_state;
        door_cnt_next = door_cnt;
        unique case (door_state)
            DOOR_LOCKED: begin
                if (unlock_doors && car_speed == '0) begin
                    door_next     = DOOR_UNLOCKING;
                    door_cnt_next = '0;
                end
            end
            DOOR_UNLOCKING: begin
                // Aborting takes priority over completing the unlock.
                if (!unlock_doors || car_speed != '0) begin
                    door_next     = DOOR_LOCKING;
                    door_cnt_next = '0;
                end else if (door_cnt == DOOR_LAST) begin
                    door_next     = DOOR_OPEN;
                    door_cnt_next = '0;
                end else begin
                    door_cnt_next = door_cnt + 1'b1;
                end
            end
            DOOR_OPEN: begin
                if (!unlock_doors || car_speed != '0) begin
                    door_next     = DOOR_LOCKING;
                    door_cnt_next = '0;
                end
            end
            DOOR_LOCKING: begin
                if (door_cnt == DOOR_LAST) begin
                    door_next     = DOOR_LOCKED;
                    door_cnt_next = '0;
                end else begin
                    door_cnt_next = door_cnt + 1'b1;
                end
            end
            default: begin
                door_next     = DOOR_LOCKED;
                door_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            door_state <= DOOR_LOCKED;
            door_cnt   <= '0;
        end else begin
            door_state <= door_next;
            door_cnt   <= door_cnt_next;
        end
    end

    assign doors_open = (door_state == DOOR_OPEN);
    assign door_busy  = (door_state == DOOR_UNLOCKING) || (door_state == DOOR_LOCKING);

endmodule
